// File: rtl/tlbelo_csr_bank.sv
// ---------------------------------------------------------------------------
// tlbelo_csr_bank
//   Combined TLBELO0/TLBELO1 CSR bank for the LoongArch32 CSR unit.
//   Holds both entry-lo registers, masks writes to the architecturally
//   writable fields, supports masked (CSRXCHG) writes and runs the TLBRD
//   load sequence against the TLB read port.
//
//   Optional feature macro: TLBELO_XCHG_EN
//     defined   -> csr_wmask is honoured (CSRXCHG bit-merge)
//     undefined -> csr_wmask is ignored; every write is a full write
//
//   Ports
//     clk, rst_n                      clock, async active-low reset
//     csr_we/csr_sel/csr_wdata/       CSR write strobe, target (0=ELO0,
//       csr_wmask                       1=ELO1), data and per-bit mask
//     tlbrd_req, tlbrd_index          TLBRD start pulse and TLB index
//     tlb_rd_addr                     held TLB read index
//     tlb_rd_e/ppn0/ppn1/flags0/      TLB read-port data, sampled in the
//       flags1/g                        load cycle
//     tlbrd_busy, tlbrd_done          sequence in progress / load-cycle pulse
//     tlbelo0, tlbelo1                register values
// ---------------------------------------------------------------------------
module tlbelo_csr_bank #(
    parameter int PALEN       = 32,
    parameter int TLB_ENTRIES = 16,
    parameter int RD_LATENCY  = 1,
    parameter int IDX_W       = $clog2(TLB_ENTRIES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              csr_we,
    input  logic              csr_sel,
    input  logic [31:0]       csr_wdata,
    input  logic [31:0]       csr_wmask,
    input  logic              tlbrd_req,
    input  logic [IDX_W-1:0]  tlbrd_index,
    output logic [IDX_W-1:0]  tlb_rd_addr,
    input  logic              tlb_rd_e,
    input  logic [PALEN-13:0] tlb_rd_ppn0,
    input  logic [PALEN-13:0] tlb_rd_ppn1,
    input  logic [5:0]        tlb_rd_flags0,
    input  logic [5:0]        tlb_rd_flags1,
    input  logic              tlb_rd_g,
    output logic              tlbrd_busy,
    output logic              tlbrd_done,
    output logic [31:0]       tlbelo0,
    output logic [31:0]       tlbelo1
);
    localparam int PPN_W = PALEN - 12;
    localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    // Writable bits: V/D/PLV/MAT/G in [6:0] plus PPN in [PALEN-5:8].
    // For PALEN=36 the shift overflows to 0 and the subtraction yields all
    // ones, which is the intended full-width PPN range.
    localparam logic [31:0] WM =
        (((32'd1 << (PALEN - 4)) - 32'd1) & 32'hFFFF_FF00) | 32'h0000_007F;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [IDX_W-1:0] addr_q;
    logic             load_cyc;

    // Busy/done decode from state only: no input-to-output path.
    assign load_cyc    = (state_q == S_WAIT) && (cnt_q == '0);
    assign tlbrd_busy  = (state_q == S_WAIT);
    assign tlbrd_done  = load_cyc;
    assign tlb_rd_addr = addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (tlbrd_req) begin
                        state_q <= S_WAIT;
                        addr_q  <= tlbrd_index;
                        cnt_q   <= CNT_W'(RD_LATENCY - 1);
                    end
                end
                default: begin
                    // Requests arriving here are dropped, not queued.
                    if (load_cyc) state_q <= S_IDLE;
                    else          cnt_q   <= cnt_q - CNT_W'(1);
                end
            endcase
        end
    end

    // Effective write mask, already restricted to the writable fields.
    logic [31:0] wmask_eff;
`ifdef TLBELO_XCHG_EN
    assign wmask_eff = csr_wmask & WM;
`else
    assign wmask_eff = WM;
    logic unused_wmask;
    assign unused_wmask = ^csr_wmask;
`endif

    function automatic logic [31:0] pack_elo(input logic [PPN_W-1:0] ppn,
                                             input logic             g,
                                             input logic [5:0]       flags);
        logic [31:0] v;
        v            = '0;
        v[PALEN-5:8] = ppn;
        v[6]         = g;
        v[5:0]       = flags;
        return v;
    endfunction

    logic [1:0][31:0] elo_q;
    logic [1:0][31:0] elo_d;
    logic [1:0][31:0] ld_val;

    // A missing entry clears both registers.
    assign ld_val[0] = tlb_rd_e ? pack_elo(tlb_rd_ppn0, tlb_rd_g, tlb_rd_flags0) : '0;
    assign ld_val[1] = tlb_rd_e ? pack_elo(tlb_rd_ppn1, tlb_rd_g, tlb_rd_flags1) : '0;

    // The CSR write is merged on top of the (possibly loaded) base value, so
    // in the load cycle the written bits win and the rest take the load.
    for (genvar r = 0; r < 2; r++) begin : g_elo
        logic [31:0] base;
        logic [31:0] wm;
        assign base     = load_cyc ? ld_val[r] : elo_q[r];
        assign wm       = (csr_we && (csr_sel == 1'(r))) ? wmask_eff : '0;
        assign elo_d[r] = (base & ~wm) | (csr_wdata & wm);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) elo_q <= '0;
        else        elo_q <= elo_d;
    end

    assign tlbelo0 = elo_q[0];
    assign tlbelo1 = elo_q[1];

endmodule

// File: doc/tlbelo_csr_bank.md
# tlbelo_csr_bank

Combined, parametrised TLBELO0/TLBELO1 CSR bank for the LoongArch32 CSR unit. It holds both entry-lo registers, masks writes to architecturally writable fields, and supports masked CSRXCHG writes. It also runs a multi-cycle TLBRD load sequence against the TLB read port. The bank sits between the CSR write path and the TLB array, and drives the TLBELO values consumed by TLBWR/TLBFILL.

## Interface
- PALEN, 32, physical address width (range 13..36); PPN field is bits [PALEN-5:8].
- TLB_ENTRIES, 16, TLB entry count; IDX_W = $clog2(TLB_ENTRIES).
- RD_LATENCY, 1, TLB read-port latency in cycles (>=1).
- clk  in  1  clock. One clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- csr_we  in  1  CSR write strobe (CSRWR/CSRXCHG).
- csr_sel  in  1  write target: 0=TLBELO0, 1=TLBELO1.
- csr_wdata  in  32  write data.
- csr_wmask  in  32  per-bit write mask (CSRXCHG); all-ones for CSRWR.
- tlbrd_req  in  1  TLBRD start pulse.
- tlbrd_index  in  IDX_W  TLB index for TLBRD, sampled with tlbrd_req.
- tlb_rd_addr  out  IDX_W  held TLB read index.
- tlb_rd_e  in  1  entry exists bit from TLB.
- tlb_rd_ppn0, tlb_rd_ppn1  in  PALEN-12 each  PPN per page.
- tlb_rd_flags0, tlb_rd_flags1  in  6 each  {MAT[1:0], PLV[1:0], D, V}.
- tlb_rd_g  in  1  global bit.
- tlbrd_busy  out  1  TLBRD sequence in progress.
- tlbrd_done  out  1  one-cycle pulse in the load cycle.
- tlbelo0, tlbelo1  out  32 each  register values.

## Operation
- Field layout (both registers): V[0], D[1], PLV[3:2], MAT[5:4], G[6], bit 7 zero, PPN[PALEN-5:8], bits [31:PALEN-4] zero.
- Writable mask WM = bits [6:0] | [PALEN-5:8]. Non-writable bits always read 0.
- CSR write: reg <= (reg & ~(csr_wmask & WM)) | (csr_wdata & csr_wmask & WM). Applied at the end of the csr_we cycle in any FSM state.
- FSM states:
  - IDLE: on tlbrd_req, latch tlbrd_index into tlb_rd_addr, set cnt = RD_LATENCY-1, go to WAIT.
  - WAIT: while cnt != 0, decrement cnt. When cnt == 0, this is the load cycle: tlbrd_done = 1 and TLB inputs are sampled. Return to IDLE.
- Load, tlb_rd_e=1: tlbelo0 <= {0, ppn0, 1'b0, g, flags0}; tlbelo1 likewise with ppn1/flags1. The same G is loaded into both.
- Load, tlb_rd_e=0: both registers cleared to 0.
- tlbrd_req while busy is ignored; no queuing.
- CSR write in the load cycle: the CSR write wins on the bits it writes in its target register. Loaded values apply to all other bits.
- CSR write during WAIT (not load cycle): applied immediately, then overwritten by the load.
- Reset mid-sequence: FSM returns to IDLE, no tlbrd_done, registers cleared.

## Timing
- Reset values: tlbelo0 = tlbelo1 = 0, tlb_rd_addr = 0, tlbrd_busy = 0, tlbrd_done = 0, FSM = IDLE.
- CSR write latency: value visible the cycle after csr_we.
- tlbrd_req in cycle T (IDLE):
  - tlbrd_busy = 1 in cycles T+1..T+RD_LATENCY.
  - TLB inputs must be valid in cycle T+RD_LATENCY; tlbrd_done = 1 in that cycle only.
  - Loaded values are visible from T+RD_LATENCY+1.
- A new tlbrd_req is accepted in cycle T+RD_LATENCY+1 at the earliest. Back-to-back TLBRDs are spaced RD_LATENCY+1 cycles apart.
- tlbrd_busy and tlbrd_done are registered/state-decoded and carry no combinational path from inputs.

## Configuration
- TLBELO_XCHG_EN defined: csr_wmask honoured as above.
- TLBELO_XCHG_EN undefined: csr_wmask ignored and treated as all-ones. Every write is a full CSRWR write of the WM bits.

## Test plan
- Reset, then CSRWR TLBELO0 with 0xFFFF_FFFF (PALEN=32) -> tlbelo0 = 0x0FFF_FF7F next cycle; tlbelo1 = 0.
- TLBELO_XCHG_EN: tlbelo1=0x0000_0041, CSRXCHG wdata=0x0000_0012, mask=0x0000_0013 -> tlbelo1 = 0x0000_0052. Without the macro, the same stimulus -> 0x0000_0012.
- RD_LATENCY=3, tlbrd_req index 5 at T, e=1, ppn0=0x12345, flags0=0x1F, g=1 -> tlb_rd_addr=5; busy in T+1..T+3; done at T+3; tlbelo0 = 0x0123_455F at T+4.
- TLBRD with tlb_rd_e=0 while both registers are non-zero -> both registers read 0 after the load cycle.
- Load cycle with simultaneous CSRWR TLBELO1 wdata=0x3 -> tlbelo1 = 0x3; tlbelo0 takes the loaded value. A second tlbrd_req while busy is ignored, with exactly one done pulse.
- rst_n asserted in the middle of WAIT -> outputs return to 0 immediately, and no done pulse follows release.
